// File: rtl/router_fsm_np.sv
// ---------------------------------------------------------------------------
// router_fsm_np
//
// Control FSM for an N-output packet router. It sits between the input
// register/parity block and the per-port FIFOs. It decodes the header
// destination, waits for the target FIFO to drain, and sequences the
// load/parity/check phases. Packets with an out-of-range destination, and
// packets whose FIFO does not empty within WAIT_TIMEOUT cycles, are dropped.
// Dropped packets are counted by a saturating counter.
//
// Ports:
//   clock, reset        single clock, asynchronous active-high reset
//   pkt_valid           packet byte valid from the source
//   data_in             destination field of the header byte
//   fifo_full           full flag of the currently selected FIFO
//   fifo_empty          per-FIFO empty flags
//   soft_reset          per-FIFO read-timeout soft resets
//   parity_done         parity byte has been captured
//   low_pkt_valid       pkt_valid fell while the FIFO was full
//   write_enb_reg       FIFO write enable
//   detect_add .. drop_state   one-hot style state indications
//   busy                source must hold its data
//   dest_sel            latched one-hot destination
//   err_addr            one-cycle pulse on the first cycle of a drop
//   drop_cnt            saturating count of dropped packets
// ---------------------------------------------------------------------------
module router_fsm_np #(
    parameter int NUM_PORTS    = 3,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 16,
    parameter int CNT_W        = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic                 write_enb_reg,
    output logic                 detect_add,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 lfd_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 busy,
    output logic                 drop_state,
    output logic [NUM_PORTS-1:0] dest_sel,
    output logic                 err_addr,
    output logic [CNT_W-1:0]     drop_cnt
);

    localparam int WAIT_W = (WAIT_TIMEOUT > 2) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [3:0] {
        DECODE_ADDRESS,
        WAIT_TILL_EMPTY,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY_ERROR,
        DROP_PACKET
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] dest_sel_q, dest_sel_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;
    logic                 err_addr_q, err_addr_d;

    logic [NUM_PORTS-1:0] hdr_onehot;
    logic                 addr_ok;
    logic                 hdr_empty;
    logic                 sel_empty;
    logic                 soft_hit;

    // Header decode helpers. The one-hot value is only used when the address
    // is in range, so truncation of an out-of-range shift is harmless.
    always_comb begin
        addr_ok    = ({1'b0, data_in} < (ADDR_W + 1)'(NUM_PORTS));
        hdr_onehot = NUM_PORTS'(1) << data_in;
        hdr_empty  = |(fifo_empty & hdr_onehot);
        sel_empty  = |(fifo_empty & dest_sel_q);
        soft_hit   = |(soft_reset & dest_sel_q);
    end

    // Next-state, destination latch, wait counter and drop accounting.
    always_comb begin
        state_d    = state_q;
        dest_sel_d = dest_sel_q;
        wait_cnt_d = wait_cnt_q;
        drop_cnt_d = drop_cnt_q;
        err_addr_d = 1'b0;

        case (state_q)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    if (!addr_ok) begin
                        state_d = DROP_PACKET;
                    end else begin
                        dest_sel_d = hdr_onehot;
                        if (hdr_empty) begin
                            state_d = LOAD_FIRST_DATA;
                        end else begin
                            state_d    = WAIT_TILL_EMPTY;
                            wait_cnt_d = '0;
                        end
                    end
                end
            end
            WAIT_TILL_EMPTY: begin
                // Empty wins over timeout when both happen in one cycle.
                if (sel_empty) begin
                    state_d = LOAD_FIRST_DATA;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = DROP_PACKET;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full) begin
                    state_d = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    state_d = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) begin
                    state_d = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    state_d = DECODE_ADDRESS;
                end else if (low_pkt_valid) begin
                    state_d = LOAD_PARITY;
                end else begin
                    state_d = LOAD_DATA;
                end
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            DROP_PACKET: begin
                if (!pkt_valid) begin
                    state_d = DECODE_ADDRESS;
                end
            end
            default: state_d = DECODE_ADDRESS;
        endcase

        // A soft reset on the selected port aborts any in-flight packet.
        // Idle and dropping states have no FIFO traffic to abort.
        if (soft_hit && state_q != DECODE_ADDRESS && state_q != DROP_PACKET) begin
            state_d = DECODE_ADDRESS;
        end

        // err_addr and the counter both fire on the edge entering DROP_PACKET.
        if (state_d == DROP_PACKET && state_q != DROP_PACKET) begin
            err_addr_d = 1'b1;
            if (drop_cnt_q != CNT_MAX) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= DECODE_ADDRESS;
            dest_sel_q <= '0;
            wait_cnt_q <= '0;
            drop_cnt_q <= '0;
            err_addr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dest_sel_q <= dest_sel_d;
            wait_cnt_q <= wait_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Moore output decode.
    always_comb begin
        detect_add    = (state_q == DECODE_ADDRESS);
        lfd_state     = (state_q == LOAD_FIRST_DATA);
        ld_state      = (state_q == LOAD_DATA);
        laf_state     = (state_q == LOAD_AFTER_FULL);
        full_state    = (state_q == FIFO_FULL_STATE);
        rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
        drop_state    = (state_q == DROP_PACKET);
        write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                        (state_q == LOAD_AFTER_FULL);
        busy          = (state_q == LOAD_FIRST_DATA) || (state_q == LOAD_PARITY) ||
                        (state_q == FIFO_FULL_STATE) || (state_q == LOAD_AFTER_FULL) ||
                        (state_q == WAIT_TILL_EMPTY) || (state_q == CHECK_PARITY_ERROR);
    end

    assign dest_sel = dest_sel_q;
    assign err_addr = err_addr_q;
    assign drop_cnt = drop_cnt_q;

endmodule
